// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave backed by a DEPTH x DW byte-lane memory.
// Every request waits WAIT cycles, then terminates for exactly one cycle in
// RESP. All outputs come straight from flops.
// Optional feature: define WB_MEM_ERR_EN so that addresses >= DEPTH terminate
// with ERR_O instead of wrapping into the array and acknowledging.
// RST_I is active-low. It asserts asynchronously. Its release is expected to be
// synchronised to CLK_I upstream.
module wb_slave_mem #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [AW-1:0] ADR_I,
    input  logic [DW/8-1:0] SEL_I,
    input  logic [DW-1:0] DAT_I,
    output logic [DW-1:0] DAT_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          RTY_O
);

    localparam int          SW      = DW / 8;
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            go_resp;

    logic [DW-1:0]   mem_q [DEPTH];

    // In IDLE the request is being accepted on this very edge (WAIT=0 goes
    // straight to RESP), so it is taken from the bus. Otherwise the latched copy is used.
    logic            cur_we;
    logic [AW-1:0]   cur_adr;
    logic [SW-1:0]   cur_sel;
    logic [DW-1:0]   cur_dat;
    logic [31:0]     adr_ext;
    logic [IW-1:0]   idx;
    logic            addr_err;
    logic            wr_en;

    assign cur_we  = (state_q == ST_IDLE) ? WE_I  : we_q;
    assign cur_adr = (state_q == ST_IDLE) ? ADR_I : adr_q;
    assign cur_sel = (state_q == ST_IDLE) ? SEL_I : sel_q;
    assign cur_dat = (state_q == ST_IDLE) ? DAT_I : wdat_q;
    assign adr_ext = 32'(cur_adr);
    assign idx     = IW'(adr_ext % DEPTH_U);

`ifdef WB_MEM_ERR_EN
    assign addr_err = (adr_ext >= DEPTH_U);
`else
    assign addr_err = 1'b0;
`endif

    // A write lands on the edge that enters RESP. It is blocked while reset is held.
    assign wr_en = go_resp & cur_we & ~addr_err & RST_I;

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;
    assign RTY_O = 1'b0;

    // Next-state, request latching and registered termination outputs.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        go_resp = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (CYC_I && STB_I) begin
                    adr_d  = ADR_I;
                    we_d   = WE_I;
                    sel_d  = SEL_I;
                    wdat_d = DAT_I;
                    cnt_d  = 4'(WAIT);
                    if (WAIT == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // If the master drops the cycle, the transfer is abandoned silently.
                if (!CYC_I) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (go_resp) begin
            ack_d = ~addr_err;
            err_d = addr_err;
            if (!cur_we && !addr_err) begin
                dat_d = mem_q[idx];
            end
        end
    end

    // State, wait counter, latched request and output registers.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            // NOTE: use non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Byte-lane write port into the storage array.
    always_ff @(posedge CLK_I) begin
        // NOTE: the array has no reset. Its contents survive reset and are undefined until written.
        if (wr_en) begin
            for (int i = 0; i < SW; i++) begin
                if (cur_sel[i]) begin
                    mem_q[idx][i*8 +: 8] <= cur_dat[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: scoreboard bench for wb_slave_mem.
// u_dut (WAIT=1) runs the single-transfer, byte-lane, abort, error and reset
// scenarios. u_dut0 (WAIT=0) runs back-to-back streaming with STB held high.
// The error expectations follow WB_MEM_ERR_EN.
module tb_wb_slave_mem;

    localparam int TB_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc1, stb1, cyc0, stb0, we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] dat1, dat0;
    logic        ack1, err1, rty1, ack0, err0, rty0;

    int n_checks = 0;
    int n_errors = 0;
    int n_terms  = 0;
    int cyc_cnt  = 0;

    typedef struct {
        logic        is_err;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [31:0] model [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    wb_slave_mem #(.DW(32), .AW(8), .DEPTH(64), .WAIT(TB_WAIT)) u_dut (
        .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc1), .STB_I(stb1), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat1),
        .ACK_O(ack1), .ERR_O(err1), .RTY_O(rty1)
    );

    wb_slave_mem #(.DW(32), .AW(8), .DEPTH(64), .WAIT(0)) u_dut0 (
        .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc0), .STB_I(stb0), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat0),
        .ACK_O(ack0), .ERR_O(err0), .RTY_O(rty0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every termination of u_dut is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (ack1 || err1)) begin
            n_terms++;
            if (sb.size() == 0) begin
                check("unexpected_term", {30'd0, ack1, err1}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("term_err", 32'(err1), 32'(e.is_err));
                check("term_ack", 32'(ack1), 32'(!e.is_err));
                if (e.is_read || e.is_err) check("rdata", dat1, e.data);
            end
        end
    end

    // One transfer on u_dut. It is entered and left at posedge+1 with the slave in IDLE.
    task automatic xfer(input logic we_v, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        exp_t x;
        int   ix;
        int   n;
        ix = int'(a) % 64;
`ifdef WB_MEM_ERR_EN
        x.is_err = (a >= 8'd64);
`else
        x.is_err = 1'b0;
`endif
        x.is_read = !we_v;
        x.data    = (x.is_err || we_v) ? 32'd0 : model[ix];
        sb.push_back(x);
        if (we_v && !x.is_err) begin
            for (int i = 0; i < 4; i++) if (s[i]) model[ix][i*8 +: 8] = d[i*8 +: 8];
        end
        cyc1 = 1'b1; stb1 = 1'b1; we = we_v; adr = a; sel = s; wdat = d;
        @(posedge clk); #1;
        stb1 = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (ack1 || err1) break;
            check("dat_idle", dat1, 32'd0);
            @(posedge clk); #1;
            n++;
            if (n > 20) begin
                check("term_timeout", 32'(n), 32'(TB_WAIT));
                break;
            end
        end
        check("latency", 32'(n), 32'(TB_WAIT));
        @(posedge clk); #1;
        cyc1 = 1'b0;
    endtask

    initial begin
        int          t_prev, terms_before;
        logic [31:0] d0 [4];

        rst_n = 1'b0; cyc1 = 0; stb1 = 0; cyc0 = 0; stb0 = 0;
        we = 0; adr = '0; sel = '0; wdat = '0;
        #23;
        check("rst_ack", 32'(ack1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_rty", 32'(rty1), 32'd0);
        check("rst_dat", dat1, 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write and read-back, then a partial-lane overwrite.
        xfer(1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 8'h05, 32'h0, 4'hF);
        xfer(1'b1, 8'h05, 32'h11223344, 4'h5);
        xfer(1'b0, 8'h05, 32'h0, 4'h0);
        check("bytelane_model", model[5], 32'hDE22BE44);
        xfer(1'b1, 8'h06, 32'h0BADF00D, 4'h0);     // SEL=0 still ACKs
        xfer(1'b1, 8'h07, 32'h01020304, 4'hF);

        // Abort: CYC_I is dropped during WAIT, so the write must not land.
        terms_before = n_terms;
        cyc1 = 1'b1; stb1 = 1'b1; we = 1'b1; adr = 8'h07; sel = 4'hF; wdat = 32'hA5A5A5A5;
        @(posedge clk); #1;
        stb1 = 1'b0; cyc1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_noterm", 32'(n_terms), 32'(terms_before));
        xfer(1'b0, 8'h07, 32'h0, 4'hF);

        // Out-of-range address: either an error or a wrap into word 0x10.
        xfer(1'b1, 8'h50, 32'hCAFEF00D, 4'hF);
`ifdef WB_MEM_ERR_EN
        xfer(1'b0, 8'h50, 32'h0, 4'hF);
`else
        xfer(1'b0, 8'h10, 32'h0, 4'hF);
        check("wrap_model", model[16], 32'hCAFEF00D);
`endif

        // Reset during WAIT of a write.
        terms_before = n_terms;
        cyc1 = 1'b1; stb1 = 1'b1; we = 1'b1; adr = 8'h05; sel = 4'hF; wdat = 32'h12345678;
        @(posedge clk); #1;
        stb1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ack", 32'(ack1), 32'd0);
        check("rstw_dat", dat1, 32'd0);
        @(posedge clk); #1;
        cyc1 = 1'b0; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstw_noterm", 32'(n_terms), 32'(terms_before));
        xfer(1'b0, 8'h05, 32'h0, 4'hF);

        // Reset during the RESP cycle of a read clears the outputs at once.
        cyc1 = 1'b1; stb1 = 1'b1; we = 1'b0; adr = 8'h05;
        @(posedge clk); #1;
        stb1 = 1'b0;
        @(posedge clk); #1;
        check("rstr_pre_ack", 32'(ack1), 32'd1);
        check("rstr_pre_dat", dat1, model[5]);
        #1 rst_n = 1'b0;
        #1;
        check("rstr_ack", 32'(ack1), 32'd0);
        check("rstr_dat", dat1, 32'd0);
        @(posedge clk); #1;
        cyc1 = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // Random byte-lane traffic on four words.
        for (int i = 0; i < 4; i++) xfer(1'b1, 8'(32 + i), $urandom, 4'hF);
        for (int i = 0; i < 6; i++)
            xfer(1'b1, 8'(32 + $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) xfer(1'b0, 8'(32 + i), 32'h0, 4'hF);

        // WAIT=0 back-to-back: STB held for four writes, then four reads.
        for (int i = 0; i < 4; i++) d0[i] = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            cyc0 = 1'b1; stb0 = 1'b1; we = (pass == 0); sel = 4'hF; adr = 8'd0; wdat = d0[0];
            t_prev = 0;
            for (int i = 0; i < 4; i++) begin
                int n;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (ack0) break;
                    n++;
                    if (n > 6) begin
                        check("b2b_timeout", 32'(n), 32'd0);
                        break;
                    end
                end
                if (pass == 1) check("b2b_rdata", dat0, d0[i]);
                check("b2b_err", 32'(err0), 32'd0);
                if (i > 0) check("b2b_gap", 32'(cyc_cnt - t_prev), 32'd2);
                t_prev = cyc_cnt;
                if (i < 3) begin
                    adr = 8'(i + 1); wdat = d0[i + 1];
                end else begin
                    stb0 = 1'b0; cyc0 = 1'b0;
                end
            end
            begin
                int extra;
                extra = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (ack0) extra++;
                end
                check("b2b_extra", 32'(extra), 32'd0);
            end
        end

        @(posedge clk); #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
